gtx_frame_tx: RTL

//  Core-side framer that drives one lane of the GTX/Aurora core2gtx AXI-Stream input.

---
 rtl/gtx_frame_pkg.sv | 16 +
 rtl/gtx_frame_tx.sv | 125 ++++++++++++
 2 files changed

// File: rtl/gtx_frame_pkg.sv
// gtx_frame_pkg: lane frame format shared by the GTX framer and deframer.
package gtx_frame_pkg;

    localparam logic [15:0] SOF_MAGIC   = 16'hA55A;
    localparam int          HDR_SOF_LSB = 16;
    localparam int          HDR_SEQ_LSB = 8;
    localparam int          HDR_LEN_LSB = 0;

    typedef enum logic [1:0] {IDLE, HDR, PAY, TRL} frame_state_t;

    function automatic logic [31:0] make_header(input logic [15:0] sof, input logic [7:0] seq,
                                                input logic [7:0] len);
        return (32'(sof) << HDR_SOF_LSB) | (32'(seq) << HDR_SEQ_LSB) | (32'(len) << HDR_LEN_LSB);
    endfunction

endpackage

// File: rtl/gtx_frame_tx.sv
// gtx_frame_tx: wraps FRAME_LEN source words as header/payload/XOR-trailer frames
// onto one core2gtx lane, dropping the partial frame when the link goes down.
module gtx_frame_tx
    import gtx_frame_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          FRAME_LEN = 64,
    parameter logic [15:0] SOF_MAGIC = gtx_frame_pkg::SOF_MAGIC
) (
    input  logic              core_clk,
    input  logic              core_rst_n,
    input  logic              gtp_up,
    input  logic [DATA_W-1:0] src_tdata,
    input  logic              src_tvalid,
    output logic              src_tready,
    output logic [DATA_W-1:0] tx_tdata,
    output logic              tx_tvalid,
    input  logic              tx_tready,
    output logic              tx_tlast,
    output logic [15:0]       frame_cnt,
    output logic              abort_pulse
);

    localparam logic [8:0] LAST_IDX  = 9'(FRAME_LEN - 1);
    localparam logic [7:0] LEN_FIELD = 8'(FRAME_LEN - 1);

    frame_state_t      state, state_n;
    logic [DATA_W-1:0] tdata_n, csum, csum_n;
    logic              tvalid_n, tlast_n, abort_n;
    logic [7:0]        seq, seq_n;
    logic [8:0]        cnt, cnt_n;
    logic [15:0]       fcnt_n;
    logic              adv, take, trl_done, start;

    assign adv        = !tx_tvalid || tx_tready;
    // The first payload word is taken while the header leaves so frames stream gap-free.
    assign src_tready = (state == HDR || state == PAY) && gtp_up && adv;
    assign take       = src_tready && src_tvalid;
    assign trl_done   = state == TRL && tx_tvalid && tx_tlast && tx_tready;
    assign start      = (state == IDLE || trl_done) && gtp_up && src_tvalid && adv;

    always_comb begin
        state_n  = state;
        tdata_n  = tx_tdata;
        tvalid_n = tx_tvalid;
        tlast_n  = tx_tlast;
        csum_n   = csum;
        cnt_n    = cnt;
        seq_n    = seq;
        fcnt_n   = frame_cnt;
        abort_n  = 1'b0;
        case (state)
            IDLE: ;
            HDR, PAY: begin
                if (!gtp_up) begin
                    state_n  = IDLE;
                    tvalid_n = 1'b0;
                    tlast_n  = 1'b0;
                    abort_n  = 1'b1;
                end else if (take) begin
                    tdata_n  = src_tdata;
                    tvalid_n = 1'b1;
                    csum_n   = csum ^ src_tdata;
                    cnt_n    = cnt + 9'd1;
                    state_n  = (cnt == LAST_IDX) ? TRL : PAY;
                end else if (adv) begin
                    tvalid_n = 1'b0;
                    state_n  = PAY;
                end
            end
            TRL: begin
                // A trailer accepted as the link drops still counts as a completed frame.
                if (trl_done) begin
                    state_n  = IDLE;
                    tvalid_n = 1'b0;
                    tlast_n  = 1'b0;
                    seq_n    = seq + 8'd1;
                    fcnt_n   = frame_cnt + 16'd1;
                end else if (!gtp_up) begin
                    state_n  = IDLE;
                    tvalid_n = 1'b0;
                    tlast_n  = 1'b0;
                    abort_n  = 1'b1;
                end else if (adv) begin
                    tdata_n  = csum;
                    tvalid_n = 1'b1;
                    tlast_n  = 1'b1;
                end
            end
        endcase
        if (start) begin
            state_n  = HDR;
            tdata_n  = make_header(SOF_MAGIC, seq_n, LEN_FIELD);
            tvalid_n = 1'b1;
            tlast_n  = 1'b0;
            csum_n   = '0;
            cnt_n    = '0;
        end
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state       <= IDLE;
            tx_tdata    <= '0;
            tx_tvalid   <= 1'b0;
            tx_tlast    <= 1'b0;
            csum        <= '0;
            cnt         <= '0;
            seq         <= '0;
            frame_cnt   <= '0;
            abort_pulse <= 1'b0;
        end else begin
            state       <= state_n;
            tx_tdata    <= tdata_n;
            tx_tvalid   <= tvalid_n;
            tx_tlast    <= tlast_n;
            csum        <= csum_n;
            cnt         <= cnt_n;
            seq         <= seq_n;
            frame_cnt   <= fcnt_n;
            abort_pulse <= abort_n;
        end
    end

endmodule
